// File: rtl/band_scale_mc.sv
// band_scale_mc
//   Multi-channel pot-gain scaler. Each frame of NUM_BANDS signed audio
//   samples is multiplied band-by-band by an unsigned pot-derived gain.
//   One shared multiplier is used, and a small FSM (IDLE -> RUN -> DRAIN)
//   sequences it. Each result is shifted right by SHIFT (so a gain of
//   1<<SHIFT is unity) and then saturated to AUDIO_W bits. The completed
//   frame is flagged with a one-cycle vld_out strobe.
//
//   Optional build macro: GAIN_SLEW_EN
//     defined   - on each capture, each gain moves toward its pot value by
//                 at most SLEW_STEP.
//     undefined - each gain is loaded directly from its pot value.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   synchronous active-low reset
//   vld_in   in   one-cycle strobe, new frame on pot/audio
//   pot      in   NUM_BANDS x POT_W unsigned gains, band i at [i*POT_W +: POT_W]
//   audio    in   NUM_BANDS x AUDIO_W signed samples, band i at [i*AUDIO_W +: AUDIO_W]
//   scaled   out  NUM_BANDS x AUDIO_W signed scaled samples (registered)
//   vld_out  out  one-cycle strobe, scaled/sat updated
//   busy     out  high while a frame is being processed
//   sat      out  high if any band of the last frame clamped
module band_scale_mc #(
    parameter int NUM_BANDS = 5,
    parameter int AUDIO_W   = 16,
    parameter int POT_W     = 12,
    parameter int SHIFT     = 10,
    parameter int SLEW_STEP = 64
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           vld_in,
    input  logic [NUM_BANDS*POT_W-1:0]     pot,
    input  logic [NUM_BANDS*AUDIO_W-1:0]   audio,
    output logic [NUM_BANDS*AUDIO_W-1:0]   scaled,
    output logic                           vld_out,
    output logic                           busy,
    output logic                           sat
);

    localparam int PROD_W = POT_W + 1 + AUDIO_W;
    localparam int IDX_W  = (NUM_BANDS > 1) ? $clog2(NUM_BANDS) : 1;

    // Clamp limits expressed at product width; the lower limit is ~max,
    // i.e. -max-1.
    localparam logic signed [PROD_W-1:0] R_MAX = PROD_W'((2 ** (AUDIO_W - 1)) - 1);
    localparam logic signed [PROD_W-1:0] R_MIN = ~R_MAX;
    localparam logic [AUDIO_W-1:0] SAT_HI = {1'b0, {(AUDIO_W-1){1'b1}}};
    localparam logic [AUDIO_W-1:0] SAT_LO = {1'b1, {(AUDIO_W-1){1'b0}}};

    if (NUM_BANDS < 1 || SHIFT < 0 || SLEW_STEP < 0) begin : g_param_check
        $error("band_scale_mc: invalid parameter set");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t                     state;
    logic [IDX_W-1:0]           idx;
    logic [IDX_W-1:0]           prod_idx;
    logic                       prod_v;
    logic signed [PROD_W-1:0]   prod;
    logic                       sat_acc;

    logic [POT_W-1:0]           gain     [NUM_BANDS];
    logic [POT_W-1:0]           gain_nxt [NUM_BANDS];
    logic signed [AUDIO_W-1:0]  aud      [NUM_BANDS];

    logic signed [POT_W:0]      mul_g;
    logic signed [AUDIO_W-1:0]  mul_a;
    logic signed [PROD_W-1:0]   mult;
    logic signed [PROD_W-1:0]   r;
    logic [AUDIO_W-1:0]         wb_val;
    logic                       wb_clamp;

    // The shared multiplier stage and the saturating write-back of the
    // previous product.
    always_comb begin
        mul_g    = $signed({1'b0, gain[idx]});
        mul_a    = aud[idx];
        mult     = PROD_W'(mul_g) * PROD_W'(mul_a);
        r        = prod >>> SHIFT;
        wb_val   = r[AUDIO_W-1:0];
        wb_clamp = 1'b0;
        if (r > R_MAX) begin
            wb_val   = SAT_HI;
            wb_clamp = 1'b1;
        end else if (r < R_MIN) begin
            wb_val   = SAT_LO;
            wb_clamp = 1'b1;
        end
    end

`ifdef GAIN_SLEW_EN
    localparam logic [POT_W-1:0] STEP = POT_W'(SLEW_STEP);

    // The distance is computed in the unsigned direction of travel, so the
    // stepped value can never leave 0..2^POT_W-1.
    always_comb begin
        gain_nxt = gain;
        for (int unsigned i = 0; i < NUM_BANDS; i++) begin
            if (pot[i*POT_W +: POT_W] > gain[i]) begin
                if ((pot[i*POT_W +: POT_W] - gain[i]) > STEP)
                    gain_nxt[i] = gain[i] + STEP;
                else
                    gain_nxt[i] = pot[i*POT_W +: POT_W];
            end else begin
                if ((gain[i] - pot[i*POT_W +: POT_W]) > STEP)
                    gain_nxt[i] = gain[i] - STEP;
                else
                    gain_nxt[i] = pot[i*POT_W +: POT_W];
            end
        end
    end
`else
    always_comb begin
        gain_nxt = gain;
        for (int unsigned i = 0; i < NUM_BANDS; i++) begin
            gain_nxt[i] = pot[i*POT_W +: POT_W];
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            prod_idx <= '0;
            prod_v   <= 1'b0;
            prod     <= '0;
            sat_acc  <= 1'b0;
            scaled   <= '0;
            vld_out  <= 1'b0;
            busy     <= 1'b0;
            sat      <= 1'b0;
            for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                gain[i] <= '0;
                aud[i]  <= '0;
            end
        end else begin
            vld_out <= 1'b0;

            // Write-back runs one cycle behind the multiplier.
            if (prod_v) begin
                scaled[prod_idx*AUDIO_W +: AUDIO_W] <= wb_val;
                if (wb_clamp)
                    sat_acc <= 1'b1;
            end

            case (state)
                IDLE: begin
                    prod_v <= 1'b0;
                    if (vld_in) begin
                        for (int unsigned i = 0; i < NUM_BANDS; i++) begin
                            aud[i]  <= $signed(audio[i*AUDIO_W +: AUDIO_W]);
                            gain[i] <= gain_nxt[i];
                        end
                        idx     <= '0;
                        sat_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    prod     <= mult;
                    prod_idx <= idx;
                    prod_v   <= 1'b1;
                    idx      <= idx + IDX_W'(1);
                    if (idx == IDX_W'(NUM_BANDS - 1))
                        state <= DRAIN;
                end
                DRAIN: begin
                    // The last band is written back on this edge, so its
                    // clamp is folded into sat directly.
                    prod_v  <= 1'b0;
                    vld_out <= 1'b1;
                    sat     <= sat_acc | (prod_v & wb_clamp);
                    busy    <= 1'b0;
                    idx     <= '0;
                    state   <= IDLE;
                end
                default: begin
                    prod_v <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_band_scale_mc.sv
module tb_band_scale_mc;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         vld_in;
    logic [59:0]  pot;
    logic [79:0]  audio;
    logic [79:0]  scaled;
    logic         vld_out;
    logic         busy;
    logic         sat;

    int checks = 0;
    int errors = 0;

    band_scale_mc dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_in  (vld_in),
        .pot     (pot),
        .audio   (audio),
        .scaled  (scaled),
        .vld_out (vld_out),
        .busy    (busy),
        .sat     (sat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a frame for one edge and returns #1 after that edge.
    task automatic send(input logic [59:0] p, input logic [79:0] a);
        pot    = p;
        audio  = a;
        vld_in = 1'b1;
        step();
        vld_in = 1'b0;
    endtask

    // Counts edges until vld_out, and the sample points with busy high.
    task automatic wait_done(output int lat, output int bc);
        lat = 0;
        bc  = 0;
        while (!vld_out && lat < 20) begin
            if (busy) bc++;
            step();
            lat++;
        end
    endtask

    task automatic count_vld(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (vld_out) cnt++;
        end
    endtask

    initial begin
        int lat;
        int bc;
        int cnt;

        rst_n  = 1'b0;
        vld_in = 1'b1;
        pot    = 60'h400400400400400;
        audio  = 80'h1111_2222_3333_4444_5555;
        step();
        vld_in = 1'b0;
        step();
        chk("rst_scaled", scaled, 80'h0);
        chk("rst_vld", {79'h0, vld_out}, 80'h0);
        chk("rst_busy", {79'h0, busy}, 80'h0);
        chk("rst_sat", {79'h0, sat}, 80'h0);
        rst_n = 1'b1;
        count_vld(10, cnt);
        chk("rst_idle_no_vld", 80'(cnt), 80'h0);

`ifdef GAIN_SLEW_EN
        send(60'h400400400400400, 80'h0400_0400_0400_0400_0400);
        wait_done(lat, bc);
        chk("slew_f1", scaled, 80'h0040_0040_0040_0040_0040);
        step();
        send(60'h400400400400400, 80'h0400_0400_0400_0400_0400);
        wait_done(lat, bc);
        chk("slew_f2", scaled, 80'h0080_0080_0080_0080_0080);
        for (int f = 3; f <= 16; f++) begin
            step();
            send(60'h400400400400400, 80'h0400_0400_0400_0400_0400);
            wait_done(lat, bc);
        end
        chk("slew_f16", scaled, 80'h0400_0400_0400_0400_0400);
        step();
        send(60'h400400400400400, 80'h0400_0400_0400_0400_0400);
        wait_done(lat, bc);
        chk("slew_f17", scaled, 80'h0400_0400_0400_0400_0400);
        step();
        send(60'h3F03F03F03F03F0, 80'h0400_0400_0400_0400_0400);
        wait_done(lat, bc);
        chk("slew_small_step", scaled, 80'h03F0_03F0_03F0_03F0_03F0);
        chk("slew_sat", {79'h0, sat}, 80'h0);
`else
        // Unity gain, band0 in the low bits.
        send(60'h400400400400400, 80'h8000_7FFF_0000_EDCC_1234);
        chk("unity_busy_start", {79'h0, busy}, 80'h1);
        wait_done(lat, bc);
        chk("unity_latency", 80'(lat), 80'd6);
        chk("unity_busy_cycles", 80'(bc), 80'd6);
        chk("unity_scaled", scaled, 80'h8000_7FFF_0000_EDCC_1234);
        chk("unity_sat", {79'h0, sat}, 80'h0);
        chk("unity_busy_end", {79'h0, busy}, 80'h0);
        step();
        chk("unity_vld_one_cycle", {79'h0, vld_out}, 80'h0);
        chk("unity_hold", scaled, 80'h8000_7FFF_0000_EDCC_1234);

        // Saturation in both directions.
        send(60'hFFFFFFFFFFFFFFF, 80'h0000_0000_0000_8000_7000);
        wait_done(lat, bc);
        chk("sat_scaled", scaled, 80'h0000_0000_0000_8000_7FFF);
        chk("sat_flag", {79'h0, sat}, 80'h1);
        step();
        send(60'h400400400400400, 80'h0001_0002_0003_0004_0005);
        wait_done(lat, bc);
        chk("sat_clear_scaled", scaled, 80'h0001_0002_0003_0004_0005);
        chk("sat_clear_flag", {79'h0, sat}, 80'h0);

        // Half gain: floor toward -inf.
        step();
        send(60'h200200200200200, 80'h0000_8000_7FFF_FFFD_0003);
        wait_done(lat, bc);
        chk("round_scaled", scaled, 80'h0000_C000_3FFF_FFFE_0001);
        chk("round_sat", {79'h0, sat}, 80'h0);

        // vld_in two cycles after capture is dropped.
        step();
        send(60'h400400400400400, 80'h1111_2222_3333_4444_5555);
        step();
        send(60'hFFFFFFFFFFFFFFF, 80'h7000_7000_7000_7000_7000);
        wait_done(lat, bc);
        chk("drop_latency", 80'(lat), 80'd4);
        chk("drop_scaled", scaled, 80'h1111_2222_3333_4444_5555);
        count_vld(10, cnt);
        chk("drop_single_vld", 80'(cnt), 80'h0);

        // Reset in the third RUN cycle.
        send(60'h400400400400400, 80'h0AAA_0BBB_0CCC_0DDD_0EEE);
        step();
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("midrst_busy", {79'h0, busy}, 80'h0);
        chk("midrst_scaled", scaled, 80'h0);
        count_vld(10, cnt);
        chk("midrst_no_vld", 80'(cnt), 80'h0);
        chk("midrst_scaled_hold", scaled, 80'h0);

        send(60'h400400400400400, 80'h0AAA_0BBB_0CCC_0DDD_0EEE);
        wait_done(lat, bc);
        chk("post_rst_latency", 80'(lat), 80'd6);
        chk("post_rst_scaled", scaled, 80'h0AAA_0BBB_0CCC_0DDD_0EEE);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
